// File: rtl/pipe_ctrl_cpu_if.sv
// Instruction-fetch handshake and load/store memory port of pipe_ctrl_cpu.
// master = the core, slave = instruction source plus memory model.
interface pipe_ctrl_cpu_if #(
  parameter int DATA_W = 16
);
  logic [31:0]       instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    input  instr, instr_valid, mem_rdata, mem_ack,
    output instr_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output instr, instr_valid, mem_rdata, mem_ack,
    input  instr_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/pipe_ctrl_cpu.sv
// Multi-cycle CPU core: FETCH/EXEC/MEM/HALT FSM, register file, Z/N/C flags.
// Optional multiplier on opcode 6 enabled by defining CPU_MUL_EN.
module pipe_ctrl_cpu #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 4,
  parameter int PC_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipe_ctrl_cpu_if.master   bus,
  output logic [PC_W-1:0]   pc_out,
  output logic [DATA_W-1:0] alu_result,
  output logic              branch_taken,
  output logic              halted
);
  localparam int RA_W = $clog2(NREGS);

  localparam logic [3:0] OP_ALU  = 4'd0;
  localparam logic [3:0] OP_ALUI = 4'd1;
  localparam logic [3:0] OP_BR   = 4'd2;
  localparam logic [3:0] OP_LD   = 4'd3;
  localparam logic [3:0] OP_ST   = 4'd4;
  localparam logic [3:0] OP_HALT = 4'd5;
  localparam logic [3:0] OP_MUL  = 4'd6;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  // Returns {carry, result}; carry is no-borrow for SUB and the shifted-out bit for shifts.
  function automatic logic [DATA_W:0] alu_op(input logic [2:0] f,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    logic [DATA_W:0] r;
    r = '0;
    case (f)
      3'b000:  r = {1'b0, a} + {1'b0, b};
      3'b001:  r = {(a >= b), a - b};
      3'b010:  r = {1'b0, a & b};
      3'b011:  r = {1'b0, a | b};
      3'b100:  r = {1'b0, a ^ b};
      3'b101:  r = {1'b0, ~a};
      3'b110:  r = {a[DATA_W-1], a[DATA_W-2:0], 1'b0};
      default: r = {a[0], 1'b0, a[DATA_W-1:1]};
    endcase
    return r;
  endfunction

  function automatic logic br_cond(input logic [2:0] f, input logic z,
                                   input logic n, input logic c);
    logic t;
    case (f)
      3'b000:  t = 1'b1;
      3'b001:  t = z;
      3'b010:  t = !z;
      3'b011:  t = n;
      3'b100:  t = !n;
      3'b101:  t = c;
      3'b110:  t = !c;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              z_q, z_d, n_q, n_d, c_q, c_d;
  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic              branch_taken_q, branch_taken_d;
  logic              halted_q, halted_d;
  logic              instr_ready_q, instr_ready_d;

  logic [3:0]          opcode;
  logic [2:0]          f3;
  logic [RA_W-1:0]     rd, rs1, rs2;
  logic signed [12:0]  imm_s;
  logic [DATA_W-1:0]   imm_x, rs1_v, rs2_v, alu_b;
  logic [PC_W-1:0]     imm_pc;
  logic [DATA_W:0]     alu_out;
  logic                unused_ir;

  assign opcode    = ir_q[31:28];
  assign f3        = ir_q[27:25];
  assign rd        = ir_q[21 +: RA_W];
  assign rs1       = ir_q[17 +: RA_W];
  assign rs2       = ir_q[13 +: RA_W];
  assign imm_s     = $signed(ir_q[12:0]);
  assign imm_x     = DATA_W'(imm_s);
  assign imm_pc    = PC_W'(imm_s);
  assign rs1_v     = regs_q[rs1];
  assign rs2_v     = regs_q[rs2];
  assign alu_b     = (opcode == OP_ALU) ? rs2_v : imm_x;
  assign alu_out   = alu_op(f3, rs1_v, alu_b);
  assign unused_ir = ^ir_q;

`ifdef CPU_MUL_EN
  logic [DATA_W-1:0] mul_res;
  assign mul_res = rs1_v * rs2_v;
`endif

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    ir_d           = ir_q;
    regs_d         = regs_q;
    z_d            = z_q;
    n_d            = n_q;
    c_d            = c_q;
    alu_result_d   = alu_result_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    branch_taken_d = 1'b0;
    halted_d       = halted_q;
    case (state_q)
      S_FETCH: begin
        if (bus.instr_valid && instr_ready_q) begin
          ir_d    = bus.instr;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_q + PC_W'(1);
        case (opcode)
          OP_ALU, OP_ALUI: begin
            regs_d[rd]   = alu_out[DATA_W-1:0];
            alu_result_d = alu_out[DATA_W-1:0];
            z_d          = (alu_out[DATA_W-1:0] == '0);
            n_d          = alu_out[DATA_W-1];
            c_d          = alu_out[DATA_W];
          end
          OP_BR: begin
            if (br_cond(f3, z_q, n_q, c_q)) begin
              pc_d           = pc_q + imm_pc;
              branch_taken_d = 1'b1;
            end
          end
          OP_LD, OP_ST: begin
            mem_req_d   = 1'b1;
            mem_we_d    = (opcode == OP_ST);
            mem_addr_d  = rs1_v + imm_x;
            mem_wdata_d = rs2_v;
            pc_d        = pc_q;
            state_d     = S_MEM;
          end
          OP_HALT: begin
            halted_d = 1'b1;
            pc_d     = pc_q;
            state_d  = S_HALT;
          end
`ifdef CPU_MUL_EN
          OP_MUL: begin
            regs_d[rd]   = mul_res;
            alu_result_d = mul_res;
            z_d          = (mul_res == '0);
            n_d          = mul_res[DATA_W-1];
            c_d          = 1'b0;
          end
`endif
          default: ;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ack) begin
          if (!mem_we_q) regs_d[rd] = bus.mem_rdata;
          pc_d      = pc_q + PC_W'(1);
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = S_FETCH;
        end
      end
      default: ;
    endcase
    instr_ready_d = (state_d == S_FETCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_FETCH;
      pc_q           <= '0;
      ir_q           <= '0;
      regs_q         <= '{default: '0};
      z_q            <= 1'b0;
      n_q            <= 1'b0;
      c_q            <= 1'b0;
      alu_result_q   <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      branch_taken_q <= 1'b0;
      halted_q       <= 1'b0;
      instr_ready_q  <= 1'b1;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      ir_q           <= ir_d;
      regs_q         <= regs_d;
      z_q            <= z_d;
      n_q            <= n_d;
      c_q            <= c_d;
      alu_result_q   <= alu_result_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      branch_taken_q <= branch_taken_d;
      halted_q       <= halted_d;
      instr_ready_q  <= instr_ready_d;
    end
  end

  assign bus.instr_ready = instr_ready_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign pc_out          = pc_q;
  assign alu_result      = alu_result_q;
  assign branch_taken    = branch_taken_q;
  assign halted          = halted_q;
endmodule

// File: tb/tb_pipe_ctrl_cpu.sv
// Scoreboard bench for pipe_ctrl_cpu: expected ALU results are queued when an
// instruction is driven and compared when the core retires it.
module tb_pipe_ctrl_cpu;
  localparam int DATA_W = 16;
  localparam int NREGS  = 4;
  localparam int PC_W   = 16;

  logic clk;
  logic rst;
  logic [PC_W-1:0]   pc_out;
  logic [DATA_W-1:0] alu_result;
  logic              branch_taken;
  logic              halted;

  pipe_ctrl_cpu_if #(.DATA_W(DATA_W)) bus ();

  pipe_ctrl_cpu #(.DATA_W(DATA_W), .NREGS(NREGS), .PC_W(PC_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .pc_out       (pc_out),
    .alu_result   (alu_result),
    .branch_taken (branch_taken),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [PC_W-1:0] exp_pc;
  logic [31:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc(input int op, input int f3, input int rd,
                                      input int rs1, input int rs2, input int imm);
    logic [31:0] w;
    w = {op[3:0], f3[2:0], rd[3:0], rs1[3:0], rs2[3:0], imm[12:0]};
    return w;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_pc = '0;
  endtask

  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    while (!bus.instr_ready && n < 50) begin
      step();
      n++;
    end
    if (!bus.instr_ready) check_eq("ready_wait", 32'(bus.instr_ready), 32'd1);
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
  endtask

  task automatic run_alu(input string tag, input logic [31:0] w, input logic [31:0] exp);
    exp_q.push_back(exp);
    send(w);
    step();
    exp_pc = exp_pc + 16'd1;
    check_eq(tag, 32'(alu_result), exp_q.pop_front());
    check_eq({tag, "_pc"}, 32'(pc_out), 32'(exp_pc));
  endtask

  task automatic run_br(input string tag, input int f3, input int imm, input logic taken);
    send(enc(2, f3, 0, 0, 0, imm));
    step();
    exp_pc = taken ? exp_pc + 16'(imm) : exp_pc + 16'd1;
    check_eq({tag, "_bt"}, 32'(branch_taken), 32'(taken));
    check_eq({tag, "_pc"}, 32'(pc_out), 32'(exp_pc));
  endtask

  task automatic run_mem(input string tag, input logic [31:0] w, input logic we,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input int wait_n, input logic [15:0] rdata);
    send(w);
    step();
    for (int i = 0; i < wait_n; i++) begin
      check_eq({tag, "_req"}, 32'(bus.mem_req), 32'd1);
      check_eq({tag, "_addr"}, 32'(bus.mem_addr), 32'(addr));
      check_eq({tag, "_we"}, 32'(bus.mem_we), 32'(we));
      check_eq({tag, "_rdy"}, 32'(bus.instr_ready), 32'd0);
      if (we) check_eq({tag, "_wdata"}, 32'(bus.mem_wdata), 32'(wdata));
      step();
    end
    check_eq({tag, "_req_last"}, 32'(bus.mem_req), 32'd1);
    check_eq({tag, "_addr_last"}, 32'(bus.mem_addr), 32'(addr));
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rdata;
    step();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'hDEAD;
    exp_pc = exp_pc + 16'd1;
    check_eq({tag, "_req_drop"}, 32'(bus.mem_req), 32'd0);
    check_eq({tag, "_rdy_back"}, 32'(bus.instr_ready), 32'd1);
    check_eq({tag, "_pc"}, 32'(pc_out), 32'(exp_pc));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.instr = '0;
    bus.instr_valid = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    exp_pc = '0;
    do_reset();
    check_eq("rst_pc", 32'(pc_out), 32'd0);
    check_eq("rst_ready", 32'(bus.instr_ready), 32'd1);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_req", 32'(bus.mem_req), 32'd0);
    check_eq("rst_we", 32'(bus.mem_we), 32'd0);
    check_eq("rst_bt", 32'(branch_taken), 32'd0);
    check_eq("rst_alu", 32'(alu_result), 32'd0);

    // ADDI / SUB; flags probed with imm=+1 branches
    run_alu("addi5", enc(1, 0, 1, 0, 0, 5), 32'd5);
    run_alu("addi3", enc(1, 0, 2, 0, 0, 3), 32'd3);
    run_alu("sub",   enc(0, 1, 3, 1, 2, 0), 32'd2);
    run_br("brz0", 1, 1, 1'b0);
    run_br("brc1", 5, 1, 1'b1);
    step();
    check_eq("bt_pulse", 32'(branch_taken), 32'd0);
    run_br("brn0", 3, 1, 1'b0);

    // Carry/negative from ADD, backward branch
    do_reset();
    run_alu("addim1", enc(1, 0, 1, 0, 0, 13'h1FFF), 32'hFFFF);
    run_alu("add_ff", enc(0, 0, 2, 1, 1, 0), 32'hFFFE);
    run_br("brc_back", 5, -2, 1'b1);
    check_eq("back_pc0", 32'(pc_out), 32'd0);
    step();
    check_eq("bt_pulse2", 32'(branch_taken), 32'd0);
    run_br("brn1", 3, 1, 1'b1);
    run_br("brnc0", 6, 1, 1'b0);
    run_alu("sub_z", enc(0, 1, 3, 1, 1, 0), 32'd0);
    run_br("brz1", 1, 1, 1'b1);
    run_br("brnz0", 2, 1, 1'b0);
    run_alu("shl", enc(0, 6, 3, 2, 0, 0), 32'hFFFC);
    run_br("brc_shl", 5, 1, 1'b1);
    run_alu("shr", enc(0, 7, 3, 1, 0, 0), 32'h7FFF);
    run_br("brnn1", 4, 1, 1'b1);
    run_alu("and", enc(0, 2, 3, 1, 2, 0), 32'hFFFE);
    run_alu("xor", enc(0, 4, 3, 1, 2, 0), 32'h0001);
    run_alu("not", enc(0, 5, 3, 2, 0, 0), 32'h0001);
    run_br("brnever", 7, 1, 1'b0);
    run_br("bralways", 0, 3, 1'b1);

    // Store with 3-cycle ack delay, then load back
    run_mem("st", enc(4, 0, 0, 0, 1, 16'h10), 1'b1, 16'h0010, 16'hFFFF, 3, 16'h0000);
    run_mem("ld", enc(3, 0, 3, 0, 0, 16'h10), 1'b0, 16'h0010, 16'h0000, 0, 16'hABCD);
    run_alu("ld_val", enc(0, 3, 2, 3, 0, 0), 32'hABCD);

    // Reset in the middle of a memory access
    send(enc(3, 0, 2, 0, 0, 16'h20));
    step();
    check_eq("abort_req_pre", 32'(bus.mem_req), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_pc = '0;
    check_eq("abort_req", 32'(bus.mem_req), 32'd0);
    check_eq("abort_rdy", 32'(bus.instr_ready), 32'd1);
    check_eq("abort_pc", 32'(pc_out), 32'd0);
    run_alu("abort_r2", enc(0, 3, 3, 2, 0, 0), 32'd0);

    // instr_valid pattern 1,1,0 repeating: high during EXEC must be ignored
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.instr       = enc(1, 0, 1, 1, 0, 1 << i);
      bus.instr_valid = (i % 3 != 2);
      step();
    end
    bus.instr_valid = 1'b0;
    step();
    check_eq("tog_alu", 32'(alu_result), 32'd73);
    check_eq("tog_pc", 32'(pc_out), 32'd3);
    exp_pc = 16'd3;

    // HALT holds until reset
    send(enc(5, 0, 0, 0, 0, 0));
    step();
    check_eq("halt_h", 32'(halted), 32'd1);
    check_eq("halt_rdy", 32'(bus.instr_ready), 32'd0);
    check_eq("halt_pc", 32'(pc_out), 32'(exp_pc));
    bus.instr       = enc(1, 0, 1, 0, 0, 7);
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 10; i++) step();
    bus.instr_valid = 1'b0;
    check_eq("halt_h10", 32'(halted), 32'd1);
    check_eq("halt_rdy10", 32'(bus.instr_ready), 32'd0);
    check_eq("halt_pc10", 32'(pc_out), 32'(exp_pc));
    check_eq("halt_alu10", 32'(alu_result), 32'd73);
    do_reset();
    check_eq("unhalt_pc", 32'(pc_out), 32'd0);
    check_eq("unhalt_h", 32'(halted), 32'd0);
    check_eq("unhalt_rdy", 32'(bus.instr_ready), 32'd1);

    // Opcode 6
    run_alu("m300a", enc(1, 0, 1, 0, 0, 300), 32'd300);
    run_alu("m300b", enc(1, 0, 2, 0, 0, 300), 32'd300);
`ifdef CPU_MUL_EN
    run_alu("mul", enc(6, 0, 3, 1, 2, 0), 32'h5F90);
    run_br("mul_z", 1, 1, 1'b0);
    run_br("mul_c", 5, 1, 1'b0);
    run_br("mul_nc", 6, 1, 1'b1);
`else
    run_alu("mul_nop", enc(6, 0, 3, 1, 2, 0), 32'd300);
    run_alu("mul_rd", enc(0, 3, 2, 3, 0, 0), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
